// File: rtl/decode_stage.sv
// decode_stage: one-entry decode pipeline register for 9-bit machine code.
// An internal mode register selects between reg-reg (mode 0) and reg-imm
// (mode 1) decoding. Opcode 0 is a mode-switch instruction: it is still
// passed downstream, but it flips the mode seen by the next accepted code.
module decode_stage #(
  parameter int REG_W = 3,
  parameter int IMM_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [8:0]       mach_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       opcode,
  output logic [REG_W-1:0] reg1,
  output logic [REG_W-1:0] reg2,
  output logic [IMM_W-1:0] immediate,
  output logic             mode,
  output logic             mode_switch,
  output logic             cur_mode
);

  // Maps the 3-bit reg-imm immediate field onto its value table.
  function automatic logic [6:0] imm_lookup(input logic [2:0] sel);
    logic [6:0] val;
    case (sel)
      3'd0:    val = 7'd0;
      3'd1:    val = 7'd1;
      3'd2:    val = 7'd4;
      3'd3:    val = 7'd8;
      3'd4:    val = 7'd16;
      3'd5:    val = 7'd32;
      3'd6:    val = 7'd64;
      3'd7:    val = 7'd127;
      default: val = 7'd0;
    endcase
    return val;
  endfunction

  logic             r_out_valid;
  logic             r_cur_mode;
  logic [4:0]       r_opcode;
  logic [REG_W-1:0] r_reg1;
  logic [REG_W-1:0] r_reg2;
  logic [IMM_W-1:0] r_immediate;
  logic             r_mode;
  logic             r_mode_switch;

  logic             w_accept;
  logic [4:0]       w_opcode;
  logic [REG_W-1:0] w_reg1;
  logic [REG_W-1:0] w_reg2;
  logic [IMM_W-1:0] w_immediate;
  logic             w_mode_switch;

  // Ready whenever the slot is empty or being drained, except during flush or reset.
  assign in_ready = reset_n && !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Decode the presented code according to the current mode.
  always_comb begin
    w_opcode      = 5'd0;
    w_reg1        = {REG_W{1'b0}};
    w_reg2        = {REG_W{1'b0}};
    w_immediate   = {IMM_W{1'b0}};
    w_mode_switch = 1'b0;
    case (r_cur_mode)
      1'b0: begin
        w_opcode    = mach_code[8:4];
        w_reg1      = {{(REG_W-2){1'b0}}, mach_code[3:2]};
        w_reg2      = {{(REG_W-2){1'b0}}, mach_code[1:0]};
        w_immediate = {IMM_W{1'b0}};
      end
      1'b1: begin
        w_opcode    = {2'b00, mach_code[8:6]};
        w_reg1      = {{(REG_W-3){1'b0}}, mach_code[5:3]};
        w_reg2      = {{(REG_W-3){1'b0}}, mach_code[2:0]};
        w_immediate = {{(IMM_W-7){1'b0}}, imm_lookup(mach_code[2:0])};
      end
      default: begin
        w_opcode    = 5'd0;
      end
    endcase
    if (w_opcode == 5'd0) begin
      w_mode_switch = 1'b1;
    end else begin
      w_mode_switch = 1'b0;
    end
  end

  // Output entry register and mode register; reset beats flush beats accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_cur_mode    <= 1'b0;
      r_opcode      <= 5'd0;
      r_reg1        <= {REG_W{1'b0}};
      r_reg2        <= {REG_W{1'b0}};
      r_immediate   <= {IMM_W{1'b0}};
      r_mode        <= 1'b0;
      r_mode_switch <= 1'b0;
    end else if (flush) begin
      r_out_valid   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid   <= 1'b1;
      r_opcode      <= w_opcode;
      r_reg1        <= w_reg1;
      r_reg2        <= w_reg2;
      r_immediate   <= w_immediate;
      r_mode        <= r_cur_mode;
      r_mode_switch <= w_mode_switch;
      if (w_mode_switch) begin
        r_cur_mode  <= !r_cur_mode;
      end else begin
        r_cur_mode  <= r_cur_mode;
      end
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end else begin
      r_out_valid   <= r_out_valid;
    end
  end

  assign out_valid   = r_out_valid;
  assign cur_mode    = r_cur_mode;
  assign opcode      = r_opcode;
  assign reg1        = r_reg1;
  assign reg2        = r_reg2;
  assign immediate   = r_immediate;
  assign mode        = r_mode;
  assign mode_switch = r_mode_switch;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios followed by
// random traffic, all compared against a behavioural model of the stage.
module tb_decode_stage;

  logic       clk;
  logic       reset_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] mach_code;
  logic       out_valid;
  logic       out_ready;
  logic [4:0] opcode;
  logic [2:0] reg1;
  logic [2:0] reg2;
  logic [7:0] immediate;
  logic       mode;
  logic       mode_switch;
  logic       cur_mode;

  decode_stage #(.REG_W(3), .IMM_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .mach_code(mach_code),
    .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .reg1(reg1), .reg2(reg2), .immediate(immediate),
    .mode(mode), .mode_switch(mode_switch), .cur_mode(cur_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: the held entry plus the mode register.
  int m_valid = 0;
  int m_mode  = 0;
  int m_op = 0, m_r1 = 0, m_r2 = 0, m_imm = 0, m_emode = 0, m_ms = 0;
  int imm_tab [8] = '{0, 1, 4, 8, 16, 32, 64, 127};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_ready();
    return (reset_n && !flush && (!m_valid || out_ready)) ? 1 : 0;
  endfunction

  // Advance the model by one clock edge using the current inputs.
  task automatic model_edge();
    int code;
    code = int'(mach_code);
    if (!reset_n) begin
      m_valid = 0; m_mode = 0;
      m_op = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_emode = 0; m_ms = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (in_valid && model_ready() == 1) begin
      if (m_mode == 0) begin
        m_op = code / 16; m_r1 = (code / 4) % 4; m_r2 = code % 4; m_imm = 0;
      end else begin
        m_op = code / 64; m_r1 = (code / 8) % 8; m_r2 = code % 8; m_imm = imm_tab[code % 8];
      end
      m_emode = m_mode;
      m_ms    = (m_op == 0) ? 1 : 0;
      m_valid = 1;
      if (m_ms == 1) m_mode = 1 - m_mode;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  // One clock: check in_ready, step model at the edge, check outputs on the falling edge.
  task automatic cycle();
    #1;
    chk("in_ready", in_ready, model_ready());
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("out_valid", out_valid, m_valid);
    chk("cur_mode", cur_mode, m_mode);
    chk("opcode", opcode, m_op);
    chk("reg1", reg1, m_r1);
    chk("reg2", reg2, m_r2);
    chk("immediate", immediate, m_imm);
    chk("mode", mode, m_emode);
    chk("mode_switch", mode_switch, m_ms);
  endtask

  logic [4:0] s_op;
  logic [2:0] s_r1, s_r2;
  logic [7:0] s_imm;
  logic       s_cm;

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mach_code = 9'd0;
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_cur_mode", cur_mode, 32'd0);
    reset_n = 1'b1;

    // Mode-0 decode.
    in_valid = 1'b1; out_ready = 1'b1; mach_code = 9'b0_1101_0110;
    cycle();
    chk("m0_valid", out_valid, 32'd1);
    chk("m0_opcode", opcode, 32'd13);
    chk("m0_reg1", reg1, 32'd1);
    chk("m0_reg2", reg2, 32'd2);
    chk("m0_imm", immediate, 32'd0);
    chk("m0_mode", mode, 32'd0);

    // Switch to mode 1, then a reg-imm instruction.
    mach_code = 9'b0_0000_0000;
    cycle();
    chk("sw_ms", mode_switch, 32'd1);
    chk("sw_mode", mode, 32'd0);
    mach_code = 9'b101_011_110;
    cycle();
    chk("m1_opcode", opcode, 32'd5);
    chk("m1_reg1", reg1, 32'd3);
    chk("m1_reg2", reg2, 32'd6);
    chk("m1_imm", immediate, 32'd64);
    chk("m1_mode", mode, 32'd1);
    chk("m1_cur_mode", cur_mode, 32'd1);

    // Switch back from mode 1.
    mach_code = 9'b000_010_111;
    cycle();
    chk("sw1_ms", mode_switch, 32'd1);
    chk("sw1_imm", immediate, 32'd127);
    chk("sw1_cur_mode", cur_mode, 32'd0);

    // Backpressure: hold for 3 cycles, then pop and accept together.
    s_op = opcode; s_r1 = reg1; s_r2 = reg2; s_imm = immediate;
    out_ready = 1'b0; mach_code = 9'b1_0000_0001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_in_ready", in_ready, 32'd0);
      chk("bp_opcode", opcode, s_op);
      chk("bp_reg1", reg1, s_r1);
      chk("bp_reg2", reg2, s_r2);
      chk("bp_imm", immediate, s_imm);
    end
    out_ready = 1'b1;
    cycle();
    chk("pop_acc_valid", out_valid, 32'd1);
    chk("pop_acc_opcode", opcode, 32'd16);

    // Flush with an entry held and new code waiting.
    out_ready = 1'b0;
    s_cm = cur_mode;
    flush = 1'b1; mach_code = 9'b0_0000_0000;
    #1;
    chk("flush_in_ready", in_ready, 32'd0);
    cycle();
    chk("flush_valid", out_valid, 32'd0);
    chk("flush_cur_mode", cur_mode, s_cm);
    flush = 1'b0; out_ready = 1'b1;

    // Enter mode 1 with an entry held, then reset.
    mach_code = 9'b0_0000_0000;
    cycle();
    mach_code = 9'b111_000_001;
    cycle();
    out_ready = 1'b0;
    chk("pre_rst_cur_mode", cur_mode, 32'd1);
    chk("pre_rst_valid", out_valid, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 32'd0);
    cycle();
    chk("rst1_valid", out_valid, 32'd0);
    chk("rst1_cur_mode", cur_mode, 32'd0);
    reset_n = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      reset_n   = ($urandom_range(0, 99) != 0);
      mach_code = ($urandom_range(0, 5) == 0) ? 9'd0 : 9'($urandom_range(0, 511));
      if (mach_code[8:6] == 3'd0 && $urandom_range(0, 1) == 1) mach_code[5:0] = 6'($urandom_range(0, 63));
      cycle();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter REG_W, default 3, meaning register-index output width; legal values are REG_W >= 3.
REQ-002 SHALL have parameter IMM_W, default 8, meaning immediate output width; legal values are IMM_W >= 8.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port flush  input  1  discard the held output entry.
REQ-006 SHALL have port in_valid  input  1  mach_code is presented.
REQ-007 SHALL have port in_ready  output  1  stage accepts mach_code this cycle.
REQ-008 SHALL have port mach_code  input  9  raw instruction.
REQ-009 SHALL have port out_valid  output  1  decoded entry held.
REQ-010 SHALL have port out_ready  input  1  downstream consumes the entry.
REQ-011 SHALL have port opcode  output  5  decoded opcode.
REQ-012 SHALL have port reg1  output  REG_W  first register index.
REQ-013 SHALL have port reg2  output  REG_W  second register index.
REQ-014 SHALL have port immediate  output  IMM_W  decoded immediate.
REQ-015 SHALL have port mode  output  1  mode the held entry was decoded in (0 = reg-reg, 1 = reg-imm).
REQ-016 SHALL have port mode_switch  output  1  held entry is a mode-switch instruction.
REQ-017 SHALL have port cur_mode  output  1  current internal mode register.

Function
REQ-018 SHALL hold the mode in an internal register; it is not an input.
REQ-019 SHALL accept an instruction when in_valid && in_ready.
REQ-020 SHALL drive in_ready = !flush && (!out_valid || out_ready), giving a one-entry pipeline register with full throughput.
REQ-021 SHALL use latency 1: an accepted instruction appears on the outputs the cycle after acceptance.
REQ-022 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-023 SHALL decode in mode 0 as follows: opcode = code[8:4]; reg1 = zero-extended code[3:2]; reg2 = zero-extended code[1:0]; immediate = 0.
REQ-024 SHALL decode in mode 1 as follows: opcode = {00, code[8:6]}; reg1 = zero-extended code[5:3]; reg2 = zero-extended code[2:0].
REQ-025 SHALL decode the mode-1 immediate from code[2:0] as 0→0, 1→1, 2→4, 3→8, 4→16, 5→32, 6→64, 7→127, zero-extended to IMM_W.
REQ-026 SHALL treat decoded opcode == 0 as a mode-switch instruction: set mode_switch = 1 for that entry and toggle the mode register on acceptance.
REQ-027 SHALL apply a toggle only to the next accepted instruction; the switch instruction itself reports the pre-toggle mode.
REQ-028 SHALL pass mode-switch instructions downstream as entries and SHALL NOT drop them.
REQ-029 SHALL, when out_valid && out_ready with no acceptance, clear out_valid next cycle.
REQ-030 SHALL, on a simultaneous pop and accept, load the new entry with out_valid remaining 1 and no bubble.
REQ-031 SHALL, on flush, clear out_valid next cycle; no acceptance occurs that cycle because in_ready = 0.
REQ-032 SHALL leave the mode register unchanged on flush; a toggle already accepted is not undone.
REQ-033 SHALL ignore mach_code when no acceptance occurs.

Reset
REQ-034 SHALL, while reset_n = 0 at a clock edge, clear out_valid, cur_mode, opcode, reg1, reg2, immediate, mode and mode_switch to 0.
REQ-035 SHALL give reset priority over flush and acceptance; an entry or toggle in flight is discarded.
REQ-036 SHALL drive in_ready = 0 during reset.

Verification
REQ-037 Bench SHALL cover: after reset, 9'b0_1101_0110 accepted in mode 0 → next cycle out_valid = 1, opcode = 5'b01101, reg1 = 1, reg2 = 2, immediate = 0, mode = 0.
REQ-038 Bench SHALL cover: 9'b0_0000_0000 accepted, then 9'b101_011_110 accepted → first entry mode_switch = 1, mode = 0; second entry opcode = 5'b00101, reg1 = 3, reg2 = 6, immediate = 64, mode = 1; cur_mode = 1.
REQ-039 Bench SHALL cover: in mode 1, 9'b000_010_111 accepted → mode_switch = 1, immediate = 127; cur_mode returns to 0.
REQ-040 Bench SHALL cover: out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0, outputs stable; out_ready = 1 → pop and accept in the same cycle, out_valid stays 1.
REQ-041 Bench SHALL cover: flush asserted with an entry held and in_valid = 1 → in_ready = 0, out_valid = 0 next cycle, cur_mode unchanged.
REQ-042 Bench SHALL cover: reset_n = 0 while in mode 1 with an entry held → out_valid = 0 and cur_mode = 0 next cycle.
